alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and command record for the ALU sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NOT  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_NOR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
    } cmd_t;

    // Only arithmetic ops produce a meaningful carry.
    function automatic logic carry_kept(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer; DEPTH must be a power of two >= 2.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rptr_r];

    // Storage array; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + AW'(1);
            if (pop_ok_s)  rptr_r <= rptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, issues them to an external combinational ALU and returns
// responses in order. Optional operand chaining is enabled by ALU_SEQ_CHAIN_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_chain,
    output logic [2:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_op,
    output logic [3:0] rsp_c,
    output logic       rsp_carry,
    output logic       busy
);
`ifdef ALU_SEQ_CHAIN_EN
    localparam int FW = $bits(cmd_t);
`else
    localparam int FW = $bits(cmd_t) - 1;
`endif

    state_t          state_r, state_nxt_s;
    logic [FW-1:0]   wdata_s, rdata_s;
    logic            full_s, empty_s, push_s;
    logic            pop_s, load_s, capture_s, release_s;
    logic [2:0]      head_op_s;
    logic [3:0]      head_a_s, head_b_s, issue_a_s;

`ifdef ALU_SEQ_CHAIN_EN
    logic [3:0]      chain_r;
    assign wdata_s   = cmd_t'{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};
    assign issue_a_s = rdata_s[0] ? chain_r : head_a_s;
`else
    logic            chain_unused_s;
    assign chain_unused_s = cmd_chain;
    assign wdata_s   = {cmd_op, cmd_a, cmd_b};
    assign issue_a_s = head_a_s;
`endif

    assign head_op_s = rdata_s[FW-1 -: 3];
    assign head_a_s  = rdata_s[FW-4 -: 4];
    assign head_b_s  = rdata_s[FW-8 -: 4];

    // Held low during reset so nothing is accepted until the block is out of it.
    assign cmd_ready = rst_n && !full_s;
    assign push_s    = cmd_valid && cmd_ready;
    assign busy      = (state_r != ST_IDLE) || !empty_s;

    alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next state and datapath strobes; a handshake in RESPOND can pop straight into ISSUE.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    load_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                capture_s   = 1'b1;
                state_nxt_s = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    release_s = 1'b1;
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        load_s      = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_RESPOND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // ALU drive and response capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op    <= 3'd0;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_op    <= 3'd0;
            rsp_c     <= 4'd0;
            rsp_carry <= 1'b0;
        end else begin
            if (load_s) begin
                alu_op <= head_op_s;
                alu_a  <= issue_a_s;
                alu_b  <= head_b_s;
            end
            if (capture_s) begin
                rsp_valid <= 1'b1;
                rsp_op    <= alu_op;
                rsp_c     <= alu_c;
                rsp_carry <= carry_kept(alu_op) ? alu_carry : 1'b0;
            end else if (release_s) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_CHAIN_EN
    // Last captured result, fed back as operand a for chained commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         chain_r <= 4'd0;
        else if (capture_s) chain_r <= alu_c;
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and response scoreboard.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_chain;
    logic [2:0] cmd_op, alu_op, rsp_op;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_c, rsp_c;
    logic       alu_carry, rsp_valid, rsp_ready, rsp_carry, busy;

    typedef struct {
        logic [2:0] op;
        logic [3:0] c;
        logic       carry;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
        logic [3:0] ec;
        logic       ecy;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs = -1;
    bit   tput_en = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_c(rsp_c), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    // Behavioural ALU; logic ops raise carry so the sequencer must mask it.
    always_comb begin
        alu_c     = 4'd0;
        alu_carry = 1'b1;
        case (alu_op)
            3'd0:    {alu_carry, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    {alu_carry, alu_c} = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    alu_c = alu_a & alu_b;
            3'd3:    alu_c = alu_a | alu_b;
            3'd4:    alu_c = ~alu_a;
            3'd5:    alu_c = alu_a ^ alu_b;
            3'd6:    alu_c = ~(alu_a & alu_b);
            default: alu_c = ~(alu_a | alu_b);
        endcase
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got op=%0d c=%0d carry=%0d, required no response",
                         rsp_op, rsp_c, rsp_carry);
            end else begin
                e = sb_q.pop_front();
                if (rsp_op !== e.op || rsp_c !== e.c || rsp_carry !== e.carry) begin
                    n_err++;
                    $display("FAIL rsp_data: got op=%0d c=%0d carry=%0d, required op=%0d c=%0d carry=%0d",
                             rsp_op, rsp_c, rsp_carry, e.op, e.c, e.carry);
                end
            end
            if (tput_en) begin
                if (last_hs >= 0) begin
                    n_cmp++;
                    if (cyc - last_hs != 2) begin
                        n_err++;
                        $display("FAIL throughput: got gap %0d cycles, required 2", cyc - last_hs);
                    end
                end
                last_hs = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Drives one command from posedge+1 until accepted; pushes its expectation at acceptance.
    task automatic send_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic ch, input logic [3:0] ec, input logic ecy);
        int  n = 0;
        bit  done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = ch;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                sb_q.push_back('{op: op, c: ec, carry: ecy});
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cmd_accept_timeout: got cmd_ready=0 for %0d cycles, required acceptance", n);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        check(name, 8'(sb_q.size()), 8'd0);
    endtask

    initial begin
        tbl[0] = '{3'd0, 4'd8,  4'd4, 1'b0, 4'd12, 1'b0};
        tbl[1] = '{3'd1, 4'd8,  4'd4, 1'b0, 4'd4,  1'b0};
        tbl[2] = '{3'd2, 4'd8,  4'd4, 1'b0, 4'd0,  1'b0};
        tbl[3] = '{3'd3, 4'd8,  4'd4, 1'b0, 4'd12, 1'b0};
        tbl[4] = '{3'd4, 4'd8,  4'd4, 1'b0, 4'd7,  1'b0};
        tbl[5] = '{3'd5, 4'd8,  4'd4, 1'b0, 4'd12, 1'b0};
        tbl[6] = '{3'd6, 4'd8,  4'd4, 1'b0, 4'd15, 1'b0};
        tbl[7] = '{3'd7, 4'd8,  4'd4, 1'b0, 4'd3,  1'b0};
        tbl[8] = '{3'd0, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1};
        tbl[9] = '{3'd1, 4'd3,  4'd5, 1'b0, 4'd14, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
        cmd_chain = 1'b0; rsp_ready = 1'b1;
        #1;
        check("reset_rsp_valid", 8'(rsp_valid), 8'd0);
        check("reset_busy",      8'(busy),      8'd0);
        check("reset_cmd_ready", 8'(cmd_ready), 8'd0);
        check("reset_alu",       8'({alu_op, alu_a}), 8'd0);
        check("reset_rsp",       8'({rsp_op, rsp_c, rsp_carry}), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 8'(cmd_ready), 8'd1);

        // Single command latency: accept at N, rsp_valid after N+2.
        send_cmd(3'd0, 4'd8, 4'd4, 1'b0, 4'd12, 1'b0);
        @(negedge clk); check("latency_n0", 8'(rsp_valid), 8'd0);
        @(negedge clk); check("latency_n1", 8'(rsp_valid), 8'd0);
        @(negedge clk); check("latency_n2", 8'(rsp_valid), 8'd1);
        check("latency_rsp_c", 8'({rsp_c, rsp_carry}), 8'd24);
        @(posedge clk); #1;
        wait_drain("drain_single");

        // Table burst with rsp_ready held high.
        last_hs = -1;
        tput_en = 1'b1;
        for (int i = 0; i < 10; i++)
            send_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chain, tbl[i].ec, tbl[i].ecy);
        wait_drain("drain_table");
        tput_en = 1'b0;
        check("idle_after_table", 8'({busy, rsp_valid}), 8'd0);

        // Backpressure: fill the FIFO behind a stalled response.
        rsp_ready = 1'b0;
        send_cmd(3'd0, 4'd1,  4'd2,  1'b0, 4'd3,  1'b0);
        send_cmd(3'd1, 4'd9,  4'd3,  1'b0, 4'd6,  1'b0);
        send_cmd(3'd5, 4'd10, 4'd6,  1'b0, 4'd12, 1'b0);
        send_cmd(3'd7, 4'd0,  4'd0,  1'b0, 4'd15, 1'b0);
        send_cmd(3'd3, 4'd5,  4'd10, 1'b0, 4'd15, 1'b0);
        check("full_cmd_ready", 8'(cmd_ready), 8'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("held_rsp", 8'({rsp_valid, rsp_op, rsp_c}), 8'({1'b1, 3'd0, 4'd3}));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain("drain_backpressure");

        // Reset while ISSUE is active with two commands still queued.
        rsp_ready = 1'b0;
        send_cmd(3'd0, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
        send_cmd(3'd0, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        send_cmd(3'd0, 4'd3, 4'd3, 1'b0, 4'd6, 1'b0);
        send_cmd(3'd0, 4'd4, 4'd4, 1'b0, 4'd8, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("issue_before_reset", 8'({busy, rsp_valid}), 8'd2);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("midreset_rsp_valid", 8'(rsp_valid), 8'd0);
        check("midreset_busy",      8'(busy),      8'd0);
        check("midreset_cmd_ready", 8'(cmd_ready), 8'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midreset", 8'(cmd_ready), 8'd1);
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_rsp", 8'({busy, rsp_valid}), 8'd0);

`ifdef ALU_SEQ_CHAIN_EN
        send_cmd(3'd0, 4'd3,  4'd2, 1'b0, 4'd5, 1'b0);
        send_cmd(3'd0, 4'd15, 4'd1, 1'b1, 4'd6, 1'b0);
`else
        send_cmd(3'd0, 4'd3,  4'd2, 1'b0, 4'd5, 1'b0);
        send_cmd(3'd0, 4'd15, 4'd1, 1'b1, 4'd0, 1'b1);
`endif
        wait_drain("drain_chain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
